// File: rtl/uart_baud_gen_frac.sv
// Fractional UART baud generator: one m_clk domain, emits rx_tick at the oversample
// rate and tx_tick at the bit rate, with glitch-free runtime reconfiguration.
module uart_baud_gen_frac #(
  parameter int INT_W        = 16,
  parameter int FRAC_W       = 8,
  parameter int OSR_W        = 5,
  parameter int DEF_DIV_INT  = 651,
  parameter int DEF_DIV_FRAC = 11,
  parameter int DEF_OSR      = 16
) (
  input  logic              m_clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [INT_W-1:0]  cfg_div_int,
  input  logic [FRAC_W-1:0] cfg_div_frac,
  input  logic [OSR_W-1:0]  cfg_osr,
  input  logic              cfg_load,
  output logic              cfg_busy,
  output logic              rx_tick,
  output logic              tx_tick
);

  localparam logic [INT_W-1:0]  ONE_I = INT_W'(1);
  localparam logic [OSR_W-1:0]  ONE_O = OSR_W'(1);
  localparam logic [INT_W-1:0]  DEF_I = INT_W'(DEF_DIV_INT);
  localparam logic [FRAC_W-1:0] DEF_F = FRAC_W'(DEF_DIV_FRAC);
  localparam logic [OSR_W-1:0]  DEF_O = OSR_W'(DEF_OSR);

  logic [INT_W-1:0]  div_int_q, div_int_p;
  logic [FRAC_W-1:0] div_frac_q, div_frac_p;
  logic [OSR_W-1:0]  osr_q, osr_p;
  logic              pend_q;
  logic [INT_W-1:0]  cnt_q;
  logic [FRAC_W-1:0] acc_q;
  logic              carry_q;
  logic [OSR_W-1:0]  osr_cnt_q;

  logic [INT_W-1:0]  div_eff;
  logic [INT_W-1:0]  period;
  logic              terminal;
  logic [OSR_W-1:0]  osr_eff;
  logic              osr_last;
  logic [FRAC_W:0]   sum;

  // The carry is dropped at the maximum divisor so the period never wraps to zero.
  assign div_eff  = (div_int_q == '0) ? ONE_I : div_int_q;
  assign period   = div_eff + INT_W'(carry_q && (div_eff != '1));
  assign terminal = (cnt_q == period - ONE_I);
  assign osr_eff  = (osr_q == '0) ? ONE_O : osr_q;
  assign osr_last = (osr_cnt_q == osr_eff - ONE_O);
  assign sum      = {1'b0, acc_q} + {1'b0, div_frac_q};

  // NOTE: all state updates use non-blocking assignments so every branch reads the
  // pre-edge values (e.g. tx_tick sees the old osr on the edge a new config lands).
  always_ff @(posedge m_clk or posedge reset) begin
    if (reset) begin
      div_int_q  <= DEF_I;
      div_frac_q <= DEF_F;
      osr_q      <= DEF_O;
      div_int_p  <= DEF_I;
      div_frac_p <= DEF_F;
      osr_p      <= DEF_O;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      osr_cnt_q  <= '0;
      rx_tick    <= 1'b0;
      tx_tick    <= 1'b0;
      cfg_busy   <= 1'b0;
    end else begin
      // Busy stays up through the cycle following the edge that applies the config.
      cfg_busy <= cfg_load | pend_q;
      if (!enable) begin
        cnt_q     <= '0;
        acc_q     <= '0;
        carry_q   <= 1'b0;
        osr_cnt_q <= '0;
        rx_tick   <= 1'b0;
        tx_tick   <= 1'b0;
        pend_q    <= 1'b0;
        if (cfg_load) begin
          div_int_q  <= cfg_div_int;
          div_frac_q <= cfg_div_frac;
          osr_q      <= cfg_osr;
          div_int_p  <= cfg_div_int;
          div_frac_p <= cfg_div_frac;
          osr_p      <= cfg_osr;
        end else if (pend_q) begin
          div_int_q  <= div_int_p;
          div_frac_q <= div_frac_p;
          osr_q      <= osr_p;
        end
      end else begin
        rx_tick <= terminal;
        tx_tick <= terminal && osr_last;
        if (terminal) begin
          cnt_q <= '0;
          if (pend_q) begin
            div_int_q  <= div_int_p;
            div_frac_q <= div_frac_p;
            osr_q      <= osr_p;
            acc_q      <= '0;
            carry_q    <= 1'b0;
            osr_cnt_q  <= '0;
          end else begin
            acc_q     <= sum[FRAC_W-1:0];
            carry_q   <= sum[FRAC_W];
            osr_cnt_q <= osr_last ? '0 : osr_cnt_q + ONE_O;
          end
        end else begin
          cnt_q <= cnt_q + ONE_I;
        end
        // A load on a terminal edge is held for the following terminal count.
        if (cfg_load) begin
          div_int_p  <= cfg_div_int;
          div_frac_p <= cfg_div_frac;
          osr_p      <= cfg_osr;
          pend_q     <= 1'b1;
        end else if (terminal) begin
          pend_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Self-checking bench for uart_baud_gen_frac: directed scenarios plus random traffic,
// compared against a closed-form tick-time reference model.
module tb_uart_baud_gen_frac;

  logic        m_clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] cfg_div_int = '0;
  logic [7:0]  cfg_div_frac = '0;
  logic [4:0]  cfg_osr = '0;
  logic        cfg_load = 1'b0;
  logic        cfg_busy, rx_tick, tx_tick;

  uart_baud_gen_frac dut (
    .m_clk        (m_clk),
    .reset        (reset),
    .enable       (enable),
    .cfg_div_int  (cfg_div_int),
    .cfg_div_frac (cfg_div_frac),
    .cfg_osr      (cfg_osr),
    .cfg_load     (cfg_load),
    .cfg_busy     (cfg_busy),
    .rx_tick      (rx_tick),
    .tx_tick      (tx_tick)
  );

  always #5 m_clk = ~m_clk;

  int n_checks = 0;
  int n_errors = 0;
  int edge_cnt = 0;
  int s;
  int rx_q[$];
  int tx_q[$];
  int busy_q[$];

  // Reference model: tick n (1-based) of an epoch starting at edge t0 lands on edge
  // t0 + n*D + floor((n-1)*F/256); tx on every O-th tick of the epoch.
  int     m_d, m_f, m_o, p_d, p_f, p_o;
  bit     m_pend;
  longint t0;
  int     n_tk;
  bit     exp_rx, exp_tx, exp_busy;

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_reset();
    m_d = 651; m_f = 11; m_o = 16;
    p_d = 651; p_f = 11; p_o = 16;
    m_pend = 1'b0;
    t0 = edge_cnt;
    n_tk = 0;
    exp_rx = 1'b0; exp_tx = 1'b0; exp_busy = 1'b0;
  endtask

  task automatic model_edge(input bit en, input bit ld, input int d, input int f, input int o);
    longint next_t;
    exp_busy = ld | m_pend;
    exp_rx = 1'b0;
    exp_tx = 1'b0;
    if (!en) begin
      t0 = edge_cnt;
      n_tk = 0;
      if (ld) begin
        m_d = d; m_f = f; m_o = o;
        p_d = d; p_f = f; p_o = o;
      end else if (m_pend) begin
        m_d = p_d; m_f = p_f; m_o = p_o;
      end
      m_pend = 1'b0;
    end else begin
      next_t = t0 + longint'(n_tk + 1) * eff(m_d) + (longint'(n_tk) * m_f) / 256;
      if (longint'(edge_cnt) == next_t) begin
        exp_rx = 1'b1;
        n_tk++;
        exp_tx = (n_tk % eff(m_o)) == 0;
        if (m_pend) begin
          m_d = p_d; m_f = p_f; m_o = p_o;
          t0 = edge_cnt;
          n_tk = 0;
          m_pend = 1'b0;
        end
      end
      if (ld) begin
        p_d = d; p_f = f; p_o = o;
        m_pend = 1'b1;
      end
    end
  endtask

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive inputs for one cycle (at the falling edge), advance one rising edge, compare.
  task automatic step(input bit en, input bit ld, input int d, input int f, input int o);
    enable = en;
    cfg_load = ld;
    cfg_div_int = 16'(d);
    cfg_div_frac = 8'(f);
    cfg_osr = 5'(o);
    @(posedge m_clk);
    edge_cnt++;
    model_edge(en, ld, d, f, o);
    @(negedge m_clk);
    check($sformatf("rx@%0d", edge_cnt), rx_tick, exp_rx);
    check($sformatf("tx@%0d", edge_cnt), tx_tick, exp_tx);
    check($sformatf("busy@%0d", edge_cnt), cfg_busy, exp_busy);
    if (rx_tick) rx_q.push_back(edge_cnt);
    if (tx_tick) tx_q.push_back(edge_cnt);
    if (cfg_busy) busy_q.push_back(edge_cnt);
  endtask

  task automatic clear_q();
    rx_q.delete();
    tx_q.delete();
    busy_q.delete();
  endtask

  // Load a config while disabled; the next epoch starts at that edge.
  task automatic cfg_seg(input int d, input int f, input int o);
    step(1'b0, 1'b1, d, f, o);
    s = edge_cnt;
    clear_q();
  endtask

  task automatic release_reset();
    @(posedge m_clk);
    edge_cnt++;
    @(negedge m_clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int guard;
    release_reset();
    check("reset_rx", rx_tick, 0);
    check("reset_tx", tx_tick, 0);
    check("reset_busy", cfg_busy, 0);

    // Defaults 651/11/16: tick 16 at 16*651, tick 32 at 32*651 + floor(31*11/256).
    s = edge_cnt;
    clear_q();
    for (int i = 0; i < 20840; i++) step(1'b1, 1'b0, 0, 0, 0);
    check("def_ntx", tx_q.size(), 2);
    check("def_rx0", (rx_q.size() > 0) ? rx_q[0] - s : -1, 651);
    check("def_tx0", (tx_q.size() > 0) ? tx_q[0] - s : -1, 10416);
    check("def_tx1", (tx_q.size() > 1) ? tx_q[1] - s : -1, 20833);

    // div 4, osr 4: rx every 4 cycles, tx on the 4th.
    cfg_seg(4, 0, 4);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 0, 0, 0);
    check("t1_nrx", rx_q.size(), 5);
    check("t1_rx0", (rx_q.size() > 0) ? rx_q[0] - s : -1, 4);
    check("t1_rx2", (rx_q.size() > 2) ? rx_q[2] - s : -1, 12);
    check("t1_ntx", tx_q.size(), 1);
    check("t1_tx0", (tx_q.size() > 0) ? tx_q[0] - s : -1, 16);

    // Reconfigure to div 10 / osr 2 in cycle 6.
    cfg_seg(4, 0, 4);
    for (int i = 0; i < 30; i++) step(1'b1, edge_cnt == s + 6, 10, 0, 2);
    check("t3_rx1", (rx_q.size() > 1) ? rx_q[1] - s : -1, 8);
    check("t3_rx2", (rx_q.size() > 2) ? rx_q[2] - s : -1, 18);
    check("t3_rx3", (rx_q.size() > 3) ? rx_q[3] - s : -1, 28);
    check("t3_tx0", (tx_q.size() > 0) ? tx_q[0] - s : -1, 28);
    check("t3_nbusy", busy_q.size(), 2);
    check("t3_busy0", (busy_q.size() > 0) ? busy_q[0] - s : -1, 7);

    // Fractional 4 + 128/256: intervals 4,4,5,... and 1000th tick within 1 of 4500.
    cfg_seg(4, 128, 4);
    guard = 0;
    while (rx_q.size() < 1000 && guard < 6000) begin
      step(1'b1, 1'b0, 0, 0, 0);
      guard++;
    end
    check("t2_done", rx_q.size() >= 1000, 1);
    check("t2_iv0", (rx_q.size() > 0) ? rx_q[0] - s : -1, 4);
    check("t2_iv1", (rx_q.size() > 1) ? rx_q[1] - rx_q[0] : -1, 4);
    check("t2_iv2", (rx_q.size() > 2) ? rx_q[2] - rx_q[1] : -1, 5);
    check("t2_avg", (rx_q.size() >= 1000) ? ((rx_q[999] - s >= 4499) && (rx_q[999] - s <= 4501)) : 0, 1);

    // Enable dropped for cycles 10..14.
    cfg_seg(4, 0, 4);
    for (int i = 0; i < 40; i++) step(!(edge_cnt >= s + 10 && edge_cnt <= s + 14), 1'b0, 0, 0, 0);
    check("t4_nrx", rx_q.size(), 8);
    check("t4_rx2", (rx_q.size() > 2) ? rx_q[2] - s : -1, 19);
    check("t4_tx0", (tx_q.size() > 0) ? tx_q[0] - s : -1, 31);

    // div 0, osr 0: ticks every cycle, then reset mid-operation.
    cfg_seg(0, 0, 0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 0, 0, 0);
    check("t6_nrx", rx_q.size(), 10);
    check("t6_ntx", tx_q.size(), 10);
    reset = 1'b1;
    #2;
    check("rst_mid_rx", rx_tick, 0);
    check("rst_mid_tx", tx_tick, 0);
    check("rst_mid_busy", cfg_busy, 0);
    release_reset();

    // Two loads while busy: only the second (div 5) takes effect.
    cfg_seg(7, 0, 1);
    for (int i = 0; i < 20; i++) begin
      if (edge_cnt == s + 2)      step(1'b1, 1'b1, 3, 0, 1);
      else if (edge_cnt == s + 3) step(1'b1, 1'b1, 5, 0, 1);
      else                        step(1'b1, 1'b0, 0, 0, 0);
    end
    check("t6b_rx0", (rx_q.size() > 0) ? rx_q[0] - s : -1, 7);
    check("t6b_iv1", (rx_q.size() > 1) ? rx_q[1] - rx_q[0] : -1, 5);
    check("t6b_iv2", (rx_q.size() > 2) ? rx_q[2] - rx_q[1] : -1, 5);

    // Random enables and reconfigurations.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 19) != 0, $urandom_range(0, 24) == 0,
           int'($urandom_range(0, 9)), int'($urandom_range(0, 255)), int'($urandom_range(0, 4)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
